// File: rtl/staticiser_unit.sv
// Serial instruction staticiser: captures line/function fields from a scan beat and
// sequences SCAN -> ACTION -> (STOPPED) beats on the digit pulse clock.
module staticiser_unit #(
    parameter int unsigned INSTR_BITS   = 20,
    parameter int unsigned FLYBACK_TIME = 4,
    parameter int unsigned LINE_BITS    = 5,
    parameter int unsigned FUNC_LSB     = 13,
    parameter int unsigned FUNC_BITS    = 3,
    localparam int unsigned BEAT_LEN    = INSTR_BITS + FLYBACK_TIME,
    localparam int unsigned DIGIT_W     = $clog2(BEAT_LEN)
) (
    input  logic                 w_DPG,
    input  logic                 w_RESET,
    input  logic                 w_XTB,
    input  logic                 w_STORE_DATA,
    input  logic                 w_STOP,
    input  logic                 w_RUN,
    output logic [LINE_BITS-1:0] b_LINE,
    output logic [FUNC_BITS-1:0] b_FUNC,
    output logic                 w_SCAN,
    output logic                 w_ACTION,
    output logic                 w_STOPPED,
    output logic                 w_INSTR_VALID,
    output logic [DIGIT_W-1:0]   b_DIGIT
);

    typedef enum logic [1:0] {StScan, StAction, StStopped} state_e;

    localparam logic [DIGIT_W-1:0] LastDigit = DIGIT_W'(BEAT_LEN - 1);

    state_e               state_q, state_d;
    logic [DIGIT_W-1:0]   cnt_q, cnt_d, digit;
    logic [LINE_BITS-1:0] line_sh_q, line_sh_d, line_q, line_d;
    logic [FUNC_BITS-1:0] func_sh_q, func_sh_d, func_q, func_d;
    logic                 stop_pend_q, stop_pend_d;
    logic                 valid_q, valid_d;
    logic                 end_of_beat, resync;

    always_ff @(posedge w_DPG or posedge w_RESET) begin
        if (w_RESET) begin
            state_q     <= StScan;
            cnt_q       <= '0;
            line_sh_q   <= '0;
            func_sh_q   <= '0;
            line_q      <= '0;
            func_q      <= '0;
            stop_pend_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_sh_q   <= line_sh_d;
            func_sh_q   <= func_sh_d;
            line_q      <= line_d;
            func_q      <= func_d;
            stop_pend_q <= stop_pend_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        digit       = w_XTB ? '0 : cnt_q;
        end_of_beat = (digit == LastDigit);
        // XTB arriving mid-beat restarts the beat at digit 0 and drops the partial word
        resync      = w_XTB && (cnt_q != '0);
        cnt_d       = end_of_beat ? '0 : digit + DIGIT_W'(1);

        state_d     = state_q;
        line_d      = line_q;
        func_d      = func_q;
        valid_d     = 1'b0;
        stop_pend_d = stop_pend_q | w_STOP;
        line_sh_d   = resync ? '0 : line_sh_q;
        func_sh_d   = resync ? '0 : func_sh_q;

        if (state_q == StScan) begin
            for (int i = 0; i < LINE_BITS; i++) begin
                if (digit == DIGIT_W'(i)) line_sh_d[i] = w_STORE_DATA;
            end
            for (int i = 0; i < FUNC_BITS; i++) begin
                if (digit == DIGIT_W'(FUNC_LSB + i)) func_sh_d[i] = w_STORE_DATA;
            end
        end

        if (end_of_beat) begin
            unique case (state_q)
                StScan: begin
                    line_d  = line_sh_d;
                    func_d  = func_sh_d;
                    valid_d = 1'b1;
                    state_d = StAction;
                end
                StAction: begin
                    state_d = stop_pend_d ? StStopped : StScan;
                end
                StStopped: begin
                    if (w_RUN && !w_STOP) begin
                        state_d     = StScan;
                        stop_pend_d = 1'b0;
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    assign b_LINE        = line_q;
    assign b_FUNC        = func_q;
    assign b_DIGIT       = cnt_q;
    assign w_INSTR_VALID = valid_q;
    assign w_SCAN        = (state_q == StScan);
    assign w_ACTION      = (state_q == StAction);
    assign w_STOPPED     = (state_q == StStopped);

endmodule

// File: tb/tb_staticiser_unit.sv
// Self-checking bench for staticiser_unit: directed beats plus randomized traffic against a
// beat-level reference model.
module tb_staticiser_unit;

    localparam int BEAT = 24;

    logic       w_DPG = 1'b0;
    logic       w_RESET = 1'b1;
    logic       w_XTB = 1'b0;
    logic       w_STORE_DATA = 1'b0;
    logic       w_STOP = 1'b0;
    logic       w_RUN = 1'b0;
    logic [4:0] b_LINE;
    logic [2:0] b_FUNC;
    logic       w_SCAN, w_ACTION, w_STOPPED, w_INSTR_VALID;
    logic [4:0] b_DIGIT;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = scan, 1 = action, 2 = stopped
    int   m_pos;
    int   m_kind;
    logic m_word [BEAT];
    int   m_line, m_func;
    bit   m_pend, m_valid;

    staticiser_unit dut (
        .w_DPG        (w_DPG),
        .w_RESET      (w_RESET),
        .w_XTB        (w_XTB),
        .w_STORE_DATA (w_STORE_DATA),
        .w_STOP       (w_STOP),
        .w_RUN        (w_RUN),
        .b_LINE       (b_LINE),
        .b_FUNC       (b_FUNC),
        .w_SCAN       (w_SCAN),
        .w_ACTION     (w_ACTION),
        .w_STOPPED    (w_STOPPED),
        .w_INSTR_VALID(w_INSTR_VALID),
        .b_DIGIT      (b_DIGIT)
    );

    always #5 w_DPG = ~w_DPG;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int field(input int lsb, input int width);
        int v = 0;
        for (int i = 0; i < width; i++) v += (m_word[lsb + i] ? 1 : 0) << i;
        return v;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_kind = 0; m_line = 0; m_func = 0; m_pend = 0; m_valid = 0;
        for (int i = 0; i < BEAT; i++) m_word[i] = 1'b0;
    endtask

    task automatic model_edge(input logic xtb, input logic data, input logic stop,
                              input logic run);
        int d = xtb ? 0 : m_pos;
        if (xtb && m_pos != 0) begin
            for (int i = 0; i < BEAT; i++) m_word[i] = 1'b0;
        end
        if (m_kind == 0) m_word[d] = data;
        if (stop) m_pend = 1;
        m_valid = 0;
        if (d == BEAT - 1) begin
            if (m_kind == 0) begin
                m_line = field(0, 5);
                m_func = field(13, 3);
                m_valid = 1;
                m_kind = 1;
            end else if (m_kind == 1) begin
                m_kind = m_pend ? 2 : 0;
            end else if (run && !stop) begin
                m_kind = 0;
                m_pend = 0;
            end
        end
        m_pos = (d == BEAT - 1) ? 0 : d + 1;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".digit"}, 32'(b_DIGIT), 32'(m_pos));
        chk({tag, ".line"}, 32'(b_LINE), 32'(m_line));
        chk({tag, ".func"}, 32'(b_FUNC), 32'(m_func));
        chk({tag, ".valid"}, 32'(w_INSTR_VALID), 32'(m_valid));
        chk({tag, ".scan"}, 32'(w_SCAN), 32'(m_kind == 0));
        chk({tag, ".action"}, 32'(w_ACTION), 32'(m_kind == 1));
        chk({tag, ".stopped"}, 32'(w_STOPPED), 32'(m_kind == 2));
    endtask

    task automatic step(input string tag, input logic xtb, input logic data, input logic stop,
                        input logic run);
        w_XTB = xtb; w_STORE_DATA = data; w_STOP = stop; w_RUN = run;
        @(posedge w_DPG);
        model_edge(xtb, data, stop, run);
        #1;
        compare_all(tag);
    endtask

    task automatic run_beat(input string tag, input logic [23:0] word, input int stop_digit,
                            input logic run_end, input logic stop_end);
        for (int i = 0; i < BEAT; i++) begin
            step(tag, i == 0, word[i], (i == stop_digit) || (i == BEAT - 1 && stop_end),
                 (i == BEAT - 1) && run_end);
        end
    endtask

    initial begin
        model_reset();
        #2;
        compare_all("reset");
        chk("reset.onehot", 32'($countones({w_SCAN, w_ACTION, w_STOPPED})), 32'd1);
        #3 w_RESET = 1'b0;

        // Asynchronous reset at digit 9 of a scan beat
        for (int i = 0; i < 9; i++) step("pre_rst", i == 0, 1'($urandom), 1'b0, 1'b0);
        #2 w_RESET = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        chk("async_rst.digit0", 32'(b_DIGIT), 32'd0);
        #1 w_RESET = 1'b0;

        // Pattern word: line 21, function 6
        run_beat("pattern", 24'hFFDFF5, -1, 1'b0, 1'b0);
        chk("pattern.line21", 32'(b_LINE), 32'd21);
        chk("pattern.func6", 32'(b_FUNC), 32'd6);
        chk("pattern.valid", 32'(w_INSTR_VALID), 32'd1);
        chk("pattern.action", 32'(w_ACTION), 32'd1);

        // Action beat of all ones: nothing captured, back to scan
        step("act_ones", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("act_ones.valid_drop", 32'(w_INSTR_VALID), 32'd0);
        for (int i = 1; i < BEAT; i++) step("act_ones", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("act_ones.line", 32'(b_LINE), 32'd21);
        chk("act_ones.func", 32'(b_FUNC), 32'd6);
        chk("act_ones.scan", 32'(w_SCAN), 32'd1);

        // Scan, then action with STOP pulse at digit 7 -> stopped
        run_beat("scan2", 24'($urandom), -1, 1'b0, 1'b0);
        run_beat("act_stop", 24'hFFFFFF, 7, 1'b0, 1'b0);
        chk("act_stop.stopped", 32'(w_STOPPED), 32'd1);
        // Stopped beat with a scan pattern word is ignored; RUN at end restarts
        run_beat("stopped_run", 24'h000000, -1, 1'b1, 1'b0);
        chk("stopped_run.line_kept", 32'(b_LINE), 32'(m_line));
        chk("stopped_run.scan", 32'(w_SCAN), 32'd1);

        // STOP and RUN together: STOP wins
        run_beat("scan3", 24'($urandom), -1, 1'b0, 1'b0);
        run_beat("act_stop2", 24'($urandom), 3, 1'b0, 1'b0);
        run_beat("both", 24'($urandom), -1, 1'b1, 1'b1);
        chk("both.stopped", 32'(w_STOPPED), 32'd1);
        run_beat("run_only", 24'($urandom), -1, 1'b1, 1'b0);
        chk("run_only.scan", 32'(w_SCAN), 32'd1);

        // Early resync at digit 10 of a scan beat
        for (int i = 0; i < 10; i++) step("pre_sync", i == 0, 1'($urandom), 1'b0, 1'b0);
        step("resync", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("resync.digit1", 32'(b_DIGIT), 32'd1);
        chk("resync.no_valid", 32'(w_INSTR_VALID), 32'd0);
        chk("resync.scan", 32'(w_SCAN), 32'd1);
        for (int i = 1; i < BEAT; i++) step("post_sync", 1'b0, 1'($urandom), 1'b0, 1'b0);
        chk("post_sync.valid", 32'(w_INSTR_VALID), 32'd1);

        // Randomized traffic, including occasional resyncs and control pulses
        for (int n = 0; n < 1500; n++) begin
            logic xtb;
            xtb = (m_pos == 0) ? 1'($urandom) : ($urandom_range(0, 39) == 0);
            step("rand", xtb, 1'($urandom), $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) == 0);
            chk("rand.onehot", 32'($countones({w_SCAN, w_ACTION, w_STOPPED})), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/staticiser_unit.md
STATICISER_UNIT -- requirements
Module: staticiser_unit

Interface
REQ-001 Parameter INSTR_BITS, 20, data digits per beat.
REQ-002 Parameter FLYBACK_TIME, 4, blank digit periods per beat; BEAT_LEN = INSTR_BITS + FLYBACK_TIME.
REQ-003 Parameter LINE_BITS, 5, line-number field width at digits 0..LINE_BITS-1.
REQ-004 Parameter FUNC_LSB, 13, first function-field digit.
REQ-005 Parameter FUNC_BITS, 3, function-field width at digits FUNC_LSB..FUNC_LSB+FUNC_BITS-1.
REQ-006 w_DPG  in  1  digit pulse clock; all state changes on its rising edge.
REQ-007 w_RESET  in  1  reset, asynchronous, active-high.
REQ-008 w_XTB  in  1  beat marker; high on the edge that samples digit 0.
REQ-009 w_STORE_DATA  in  1  serial word from the store, LSB first, one digit per w_DPG edge.
REQ-010 w_STOP  in  1  halt request.
REQ-011 w_RUN  in  1  restart request.
REQ-012 b_LINE  out  LINE_BITS  staticised line number.
REQ-013 b_FUNC  out  FUNC_BITS  staticised function code.
REQ-014 w_SCAN, w_ACTION, w_STOPPED  out  1 each  one-hot beat-type indicators.
REQ-015 w_INSTR_VALID  out  1  one-cycle pulse after a new instruction is staticised.
REQ-016 b_DIGIT  out  $clog2(BEAT_LEN)  current digit counter value.

Function
REQ-017 Digit index d = 0 when w_XTB is high, otherwise the counter value; each edge loads the counter with 0 if d == BEAT_LEN-1, else d+1.
REQ-018 Beat FSM states SCAN, ACTION, STOPPED; transitions occur only on the edge where d == BEAT_LEN-1 (end of beat).
REQ-019 In SCAN, for d < LINE_BITS, the edge writes w_STORE_DATA into line shadow bit d.
REQ-020 In SCAN, for FUNC_LSB <= d < FUNC_LSB+FUNC_BITS, the edge writes w_STORE_DATA into function shadow bit d-FUNC_LSB.
REQ-021 All other digits, including flyback digits, are ignored; ACTION and STOPPED beats capture nothing.
REQ-022 SCAN end of beat: shadows copy to b_LINE/b_FUNC in parallel, w_INSTR_VALID is high for the following cycle only, and the state becomes ACTION.
REQ-023 b_LINE/b_FUNC hold their previous values throughout a scan beat; no partial updates are visible.
REQ-024 w_STOP high on any edge sets stop_pending; stop_pending is sticky.
REQ-025 ACTION end of beat: the state becomes STOPPED if stop_pending or w_STOP is set, else SCAN.
REQ-026 STOPPED end of beat: the state becomes SCAN and stop_pending clears if w_RUN is high and w_STOP is low; otherwise the state stays STOPPED (STOP wins).
REQ-027 w_XTB high while the counter is nonzero is an early resync.
REQ-028 An early resync aborts the current beat: no end-of-beat action and no state change.
REQ-029 An early resync clears both shadows before that edge's digit-0 capture.
REQ-030 Indicator outputs are decoded from the registered state; exactly one is high at any time.

Reset
REQ-031 w_RESET high forces counter 0, state SCAN, b_LINE 0, b_FUNC 0, shadows 0, stop_pending 0, and w_INSTR_VALID 0 immediately, without waiting for a clock edge.
REQ-032 Reset asserted mid-beat discards partial capture; the first post-reset beat begins at the next w_XTB or counter wrap.

Verification (INSTR_BITS=20, FLYBACK_TIME=4, BEAT_LEN=24)
REQ-033 Assert w_RESET at digit 9 of a scan beat -> w_SCAN=1, b_LINE=0, b_FUNC=0, b_DIGIT=0, w_INSTR_VALID=0 with no clock edge.
REQ-034 Scan-beat word with digits 0..4 = 1,0,1,0,1, digits 13..15 = 0,1,1, all other digits 1 -> after the digit-23 edge: b_LINE=21, b_FUNC=6, w_INSTR_VALID high exactly one cycle, w_ACTION=1.
REQ-035 All-ones word during the following action beat -> b_LINE=21 and b_FUNC=6 unchanged, w_SCAN=1 after the digit-23 edge.
REQ-036 w_STOP pulsed at action digit 7 -> w_STOPPED=1 after the digit-23 edge; the next scan-pattern word is not captured; w_RUN high at digit 23 of a stopped beat -> w_SCAN=1.
REQ-037 w_STOP and w_RUN both high at digit 23 of a stopped beat -> w_STOPPED remains 1.
REQ-038 w_XTB at digit 10 of a scan beat -> no transfer, no w_INSTR_VALID, b_DIGIT=1 on the next cycle; the next full beat then captures normally.
